// File: rtl/alu_seq_unit.sv
// alu_seq_unit: decoded ALU with registered result/flag/control outputs and a done pulse.
// Define ALU_SEQ_MUL_EN to build the shift-add multiplier; otherwise the MUL encoding runs as AND.
module alu_seq_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             flush,
    input  logic             ALUOp,
    input  logic [4:0]       Funct,
    input  logic [11:0]      Src2,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic [2:0]       ALUControl,
    output logic [1:0]       FlagW,
    output logic             NoWrite
);

    // state   | meaning
    // IDLE    | waiting for start
    // DONE    | outputs updated this cycle, done pulse high, new start accepted
    // MUL     | shift-add multiply in progress (ALU_SEQ_MUL_EN only)

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [2:0] OP_SLR = 3'b101;
    localparam logic [6:0] WIDTH_L = 7'(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DONE = 2'd1
`ifdef ALU_SEQ_MUL_EN
        , ST_MUL = 2'd2
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       flags_q, flags_d;
    logic [2:0]       ctrl_q, ctrl_d;
    logic [1:0]       flag_w_q, flag_w_d;
    logic             no_write_q, no_write_d;

    logic [3:0]       cmd;
    logic             s_bit;
    logic [4:0]       shamt;
    logic [2:0]       dec_op;
    logic [1:0]       dec_flag_w;
    logic             dec_no_write;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;
    logic [WIDTH-1:0] op_result;
    logic             op_c;
    logic             op_v;
    logic [3:0]       op_flags;
    logic             unused_src2;

`ifdef ALU_SEQ_MUL_EN
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);

    logic             dec_mul;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_step;
    logic             mul_s_q, mul_s_d;
`endif

    assign cmd         = Funct[4:1];
    assign s_bit       = Funct[0];
    assign shamt       = Src2[11:7];
    assign unused_src2 = ^Src2[6:0];

    always_comb begin
        dec_op       = OP_ADD;
        dec_flag_w   = 2'b00;
        dec_no_write = 1'b0;
`ifdef ALU_SEQ_MUL_EN
        dec_mul      = 1'b0;
`endif
        if (ALUOp) begin
            case (cmd)
                4'b0000: begin
                    dec_op     = OP_AND;
                    dec_flag_w = {s_bit, 1'b0};
`ifdef ALU_SEQ_MUL_EN
                    if (Src2[7:4] == 4'b1001) begin
                        dec_op  = OP_MUL;
                        dec_mul = 1'b1;
                    end
`endif
                end
                4'b0100: begin
                    dec_op     = OP_ADD;
                    dec_flag_w = {s_bit, s_bit};
                end
                4'b0010: begin
                    dec_op     = OP_SUB;
                    dec_flag_w = {s_bit, s_bit};
                end
                4'b1100: begin
                    dec_op     = OP_OR;
                    dec_flag_w = {s_bit, 1'b0};
                end
                4'b1010: begin
                    dec_op       = OP_SUB;
                    dec_flag_w   = 2'b11;
                    dec_no_write = 1'b1;
                end
                4'b1101: begin
                    dec_op     = OP_SLR;
                    dec_flag_w = 2'b11;
                end
                default: begin
                    dec_op     = OP_ADD;
                    dec_flag_w = 2'b00;
                end
            endcase
        end
    end

    // SUB carry is the no-borrow bit: a + ~b + 1 carries out exactly when a >= b.
    always_comb begin
        sum_ext   = {1'b0, a} + {1'b0, b};
        diff_ext  = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
        op_result = sum_ext[WIDTH-1:0];
        op_c      = 1'b0;
        op_v      = 1'b0;
        case (dec_op)
            OP_ADD: begin
                op_c = sum_ext[WIDTH];
                op_v = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                op_result = diff_ext[WIDTH-1:0];
                op_c      = diff_ext[WIDTH];
                op_v      = (a[WIDTH-1] != b[WIDTH-1]) && (diff_ext[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: op_result = a & b;
            OP_OR:  op_result = a | b;
            OP_SLR: begin
                op_result = b >> shamt;
                if ((shamt != 5'd0) && ({2'b00, shamt} < WIDTH_L)) begin
                    op_c = b[shamt - 5'd1];
                end
            end
            default: op_result = a & b;
        endcase
        op_flags = {op_result[WIDTH-1], (op_result == '0), op_c, op_v};
    end

`ifdef ALU_SEQ_MUL_EN
    assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
`endif

    always_comb begin
        state_d    = state_q;
        result_d   = result_q;
        flags_d    = flags_q;
        ctrl_d     = ctrl_q;
        flag_w_d   = flag_w_q;
        no_write_d = no_write_q;
`ifdef ALU_SEQ_MUL_EN
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        mul_s_d    = mul_s_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start && !flush) begin
`ifdef ALU_SEQ_MUL_EN
                    if (dec_mul) begin
                        state_d  = ST_MUL;
                        cnt_d    = CNT_LOAD;
                        acc_d    = '0;
                        mcand_d  = a;
                        mplier_d = b;
                        mul_s_d  = s_bit;
                    end else
`endif
                    begin
                        state_d    = ST_DONE;
                        result_d   = op_result;
                        flags_d    = op_flags;
                        ctrl_d     = dec_op;
                        flag_w_d   = dec_flag_w;
                        no_write_d = dec_no_write;
                    end
                end
            end
`ifdef ALU_SEQ_MUL_EN
            ST_MUL: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d    = acc_step;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    if (cnt_q == '0) begin
                        state_d    = ST_DONE;
                        result_d   = acc_step;
                        flags_d    = {acc_step[WIDTH-1], (acc_step == '0), 2'b00};
                        ctrl_d     = OP_MUL;
                        flag_w_d   = {mul_s_q, 1'b0};
                        no_write_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            result_q   <= '0;
            flags_q    <= 4'b0000;
            ctrl_q     <= OP_ADD;
            flag_w_q   <= 2'b00;
            no_write_q <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            cnt_q      <= '0;
            acc_q      <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            mul_s_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            result_q   <= result_d;
            flags_q    <= flags_d;
            ctrl_q     <= ctrl_d;
            flag_w_q   <= flag_w_d;
            no_write_q <= no_write_d;
`ifdef ALU_SEQ_MUL_EN
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            mul_s_q    <= mul_s_d;
`endif
        end
    end

`ifdef ALU_SEQ_MUL_EN
    assign ready = (state_q != ST_MUL);
    assign busy  = (state_q == ST_MUL);
`else
    assign ready = 1'b1;
    assign busy  = 1'b0;
`endif
    assign done       = (state_q == ST_DONE);
    assign result     = result_q;
    assign flags      = flags_q;
    assign ALUControl = ctrl_q;
    assign FlagW      = flag_w_q;
    assign NoWrite    = no_write_q;

endmodule
